// File: rtl/dma_tx_pkg.sv
// Shared types and defaults for the host-side TX DMA burst issuer.
// State enum, default widths, descriptor bundle shared with the fetcher.
package dma_tx_pkg;

  localparam int DEF_LEN_W   = 8;
  localparam int DEF_MAX_OUT = 8;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN,
    QUIET
  } tx_state_e;

  typedef struct packed {
    logic [DEF_LEN_W-1:0] len;
  } tx_desc_t;

endpackage

// File: rtl/dma_tx_if.sv
// Descriptor, beat and completion handshakes of the TX DMA issuer.
// master: fetcher/bus side driving requests; slave: the issuer.
interface dma_tx_if #(
  parameter int LEN_W = 8
);
  logic             desc_valid;
  logic             desc_ready;
  logic [LEN_W-1:0] desc_len;
  logic             beat_valid;
  logic             beat_ready;
  logic             beat_last;
  logic             cpl_valid;

  modport master (
    output desc_valid, desc_len, beat_ready, cpl_valid,
    input  desc_ready, beat_valid, beat_last
  );

  modport slave (
    input  desc_valid, desc_len, beat_ready, cpl_valid,
    output desc_ready, beat_valid, beat_last
  );
endinterface

// File: rtl/dma_tx_quiesce_out_cnt.sv
// Outstanding-burst up/down counter: full flag, zero-next, stray-cpl error.
// Ports: clk, rst_n, inc, cpl -> cnt, full, zero_next, err (sticky).
module dma_out_cnt #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             cpl,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             zero_next,
  output logic             err
);

  logic             dec;
  logic [CNT_W-1:0] cnt_next;

  // A completion with nothing outstanding is dropped, never wraps.
  assign dec = cpl && (cnt != '0);

  always_comb begin
    cnt_next = cnt;
    unique case ({inc, dec})
      2'b10:   cnt_next = cnt + CNT_W'(1);
      2'b01:   cnt_next = cnt - CNT_W'(1);
      default: cnt_next = cnt;
    endcase
  end

  assign full      = (cnt == CNT_W'(MAX_OUT));
  assign zero_next = (cnt_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (cpl && (cnt == '0) && !inc)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_tx_quiesce.sv
// TX DMA burst issuer with halt/quiesce tracking.
// Ports: clk, rst_n, dma_halt, bus (slave), tx_quiet, outstanding, cpl_err.
module dma_tx_quiesce
  import dma_tx_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dma_halt,
  dma_tx_if.slave          bus,
  output logic             tx_quiet,
  output logic [CNT_W-1:0] outstanding,
  output logic             cpl_err
);

  tx_state_e        state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             beat_hs;
  logic             full;
  logic             zero_next;

  // Gated by rst_n so nothing is offered while reset is held.
  assign bus.desc_ready = rst_n && (state_q == IDLE)
                        && !dma_halt && !full;
  assign accept         = bus.desc_valid && bus.desc_ready;

  assign bus.beat_valid = (state_q == BURST);
  assign bus.beat_last  = bus.beat_valid && (cnt_q == '0);
  assign beat_hs        = bus.beat_valid && bus.beat_ready;
  assign tx_quiet       = (state_q == QUIET);

  dma_out_cnt #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_out_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (accept),
    .cpl       (bus.cpl_valid),
    .cnt       (outstanding),
    .full      (full),
    .zero_next (zero_next),
    .err       (cpl_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BURST;
          cnt_d   = bus.desc_len;
        end else if (dma_halt) begin
          state_d = DRAIN;
        end
      end
      BURST: begin
        // Halt never truncates: only the last beat can leave.
        if (beat_hs) begin
          if (cnt_q == '0)
            state_d = dma_halt ? DRAIN : IDLE;
          else
            cnt_d = cnt_q - LEN_W'(1);
        end
      end
      DRAIN: begin
        if (!dma_halt)
          state_d = IDLE;
        else if (zero_next)
          state_d = QUIET;
      end
      QUIET: begin
        if (!dma_halt)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_tx_quiesce.sv
// Self-checking bench for dma_tx_quiesce: directed cases plus random
// traffic compared each cycle against a behavioural model.
module tb_dma_tx_quiesce;

  localparam int MAX_OUT = 8;

  logic       clk;
  logic       rst_n;
  logic       dma_halt;
  logic       tx_quiet;
  logic [3:0] outstanding;
  logic       cpl_err;

  dma_tx_if #(.LEN_W(8)) bus ();

  dma_tx_quiesce #(
    .LEN_W   (8),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dma_halt    (dma_halt),
    .bus         (bus),
    .tx_quiet    (tx_quiet),
    .outstanding (outstanding),
    .cpl_err     (cpl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: beats left in current burst, halt mode, quiet, count, error.
  int m_rem;
  bit m_hmode;
  bit m_quiet;
  bit m_err;
  int m_out;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic bit m_ready(input bit h);
    return (m_rem == 0) && !m_hmode && !h && (m_out < MAX_OUT);
  endfunction

  task automatic model_reset();
    m_rem   = 0;
    m_hmode = 0;
    m_quiet = 0;
    m_err   = 0;
    m_out   = 0;
  endtask

  task automatic model_update(input bit dv, input int len, input bit br,
                              input bit cv, input bit h);
    bit acc;
    bit dec;
    int on;
    acc = dv && m_ready(h);
    dec = cv && (m_out > 0);
    if (cv && m_out == 0 && !acc) m_err = 1;
    on = m_out + int'(acc) - int'(dec);
    if (m_rem > 0) begin
      if (br) begin
        m_rem--;
        if (m_rem == 0 && h) m_hmode = 1;
      end
    end else if (!m_hmode) begin
      if (acc) m_rem = len + 1;
      else if (h) m_hmode = 1;
    end else begin
      if (!h) begin
        m_hmode = 0;
        m_quiet = 0;
      end else if (on == 0) begin
        m_quiet = 1;
      end
    end
    m_out = on;
  endtask

  task automatic compare();
    chk("desc_ready", 32'(bus.desc_ready), 32'(m_ready(dma_halt)));
    chk("beat_valid", 32'(bus.beat_valid), 32'(m_rem > 0));
    chk("beat_last", 32'(bus.beat_last), 32'(m_rem == 1));
    chk("tx_quiet", 32'(tx_quiet), 32'(m_quiet));
    chk("outstanding", 32'(outstanding), 32'(m_out));
    chk("cpl_err", 32'(cpl_err), 32'(m_err));
  endtask

  task automatic step(input bit dv, input int len, input bit br,
                      input bit cv, input bit h);
    bus.desc_valid = dv;
    bus.desc_len   = 8'(len);
    bus.beat_ready = br;
    bus.cpl_valid  = cv;
    dma_halt       = h;
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update(dv, len, br, cv, h);
    #1;
  endtask

  task automatic idle_in();
    bus.desc_valid = 0;
    bus.desc_len   = 0;
    bus.beat_ready = 0;
    bus.cpl_valid  = 0;
    dma_halt       = 0;
  endtask

  initial begin
    int nb;
    int lastpos;
    bit h;
    idle_in();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    chk("rst_desc_ready", 32'(bus.desc_ready), 0);
    chk("rst_beat_valid", 32'(bus.beat_valid), 0);
    chk("rst_tx_quiet", 32'(tx_quiet), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_cpl_err", 32'(cpl_err), 0);
    @(posedge clk);
    #1 rst_n = 1;

    // Basic 4-beat burst.
    step(1, 3, 1, 0, 0);
    chk("basic_out1", 32'(outstanding), 1);
    nb = 0;
    lastpos = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.beat_valid && bus.beat_last) lastpos = nb + 1;
      if (bus.beat_valid) nb++;
      step(0, 0, 1, 0, 0);
    end
    chk("basic_beats", 32'(nb), 4);
    chk("basic_lastpos", 32'(lastpos), 4);
    step(0, 0, 1, 1, 0);
    chk("basic_out0", 32'(outstanding), 0);

    // Fill to MAX_OUT with one-beat bursts.
    for (int i = 0; i < MAX_OUT; i++) begin
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
    end
    chk("full_out", 32'(outstanding), 8);
    chk("full_ready", 32'(bus.desc_ready), 0);
    step(1, 0, 1, 0, 0);
    chk("full_blocked", 32'(outstanding), 8);
    step(0, 0, 1, 1, 0);
    chk("full_ready_back", 32'(bus.desc_ready), 1);

    // Down to 2, then accept coinciding with cpl.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
    chk("pre_same_out", 32'(outstanding), 2);
    step(1, 0, 1, 1, 0);
    chk("same_cycle_out", 32'(outstanding), 2);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("drained_out", 32'(outstanding), 0);
    step(0, 0, 1, 1, 0);
    chk("stray_err", 32'(cpl_err), 1);
    chk("stray_out", 32'(outstanding), 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("stray_sticky", 32'(cpl_err), 1);

    // Halt mid-burst with 3 outstanding.
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
    end
    step(1, 7, 1, 0, 0);
    chk("halt_out3", 32'(outstanding), 3);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.beat_valid) nb++;
      step(0, 0, 1, 0, i >= 2);
    end
    chk("halt_beats", 32'(nb), 8);
    chk("halt_beat_valid", 32'(bus.beat_valid), 0);
    chk("halt_not_quiet", 32'(tx_quiet), 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    chk("halt_still_busy", 32'(tx_quiet), 0);
    step(0, 0, 1, 1, 1);
    chk("halt_quiet", 32'(tx_quiet), 1);
    step(0, 0, 1, 0, 1);
    chk("quiet_holds", 32'(tx_quiet), 1);

    // Unhalt out of QUIET.
    step(0, 0, 1, 0, 0);
    chk("unhalt_quiet", 32'(tx_quiet), 0);
    chk("unhalt_ready", 32'(bus.desc_ready), 1);

    // Minimum halt-to-quiet latency from IDLE.
    step(0, 0, 1, 0, 1);
    chk("lat_n1", 32'(tx_quiet), 0);
    step(0, 0, 1, 0, 1);
    chk("lat_n2", 32'(tx_quiet), 1);
    step(0, 0, 1, 0, 0);

    // Reset during beat 3 of an 8-beat burst.
    step(1, 7, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("pre_rst_valid", 32'(bus.beat_valid), 1);
    rst_n = 0;
    #1;
    model_reset();
    chk("arst_beat_valid", 32'(bus.beat_valid), 0);
    chk("arst_desc_ready", 32'(bus.desc_ready), 0);
    chk("arst_out", 32'(outstanding), 0);
    chk("arst_cpl_err", 32'(cpl_err), 0);
    chk("arst_quiet", 32'(tx_quiet), 0);
    @(posedge clk);
    #1 rst_n = 1;
    step(0, 0, 1, 0, 0);

    // Random traffic.
    h = 0;
    for (int i = 0; i < 4000; i++) begin
      bit dv;
      bit br;
      bit cv;
      int len;
      if ($urandom_range(0, 39) == 0) h = !h;
      dv  = $urandom_range(0, 1) == 1;
      len = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 255)
                                         : $urandom_range(0, 5);
      br  = $urandom_range(0, 9) < 7;
      if (m_out > 0) cv = $urandom_range(0, 3) == 0;
      else           cv = $urandom_range(0, 199) == 0;
      step(dv, len, br, cv, h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_tx_quiesce.md
Name: dma_tx_quiesce

Overview:
- Host-side TX DMA burst issuer with quiesce tracking.
- Accepts burst descriptors from the TX descriptor fetcher and emits beats to the host bus. It counts outstanding bursts until their completions return.
- Responds to dma_halt from the soft reset controller and reports tx_quiet back once no burst is issuing and nothing is outstanding.
- rst_n is driven by the soft reset controller's host-side async reset.

Parameters:
- LEN_W, 8: width of desc_len. Burst length is desc_len+1 beats, so 1..256 beats at the default.
- MAX_OUT, 8: maximum outstanding (issued, uncompleted) bursts.
- CNT_W, $clog2(MAX_OUT+1): width of the outstanding counter. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dma_halt  in  1  halt request; level, synchronous to clk
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accepted when valid&&ready
- desc_len  in  LEN_W  beats-1 of the burst
- beat_valid  out  1  bus beat valid
- beat_ready  in  1  bus accepts beat
- beat_last  out  1  final beat of current burst; qualified by beat_valid
- cpl_valid  in  1  one-cycle pulse, one per completed burst
- tx_quiet  out  1  TX side dormant
- outstanding  out  CNT_W  current outstanding burst count
- cpl_err  out  1  sticky: completion received with outstanding==0

Behaviour:
- Single clock. Async assert of rst_n, registered release.
- Reset values:
  - state=IDLE, beat_cnt=0, outstanding=0, cpl_err=0.
  - desc_ready=0, beat_valid=0, beat_last=0, tx_quiet=0.
- States: IDLE, BURST, DRAIN, QUIET, held in a registered state vector.
- desc_ready is combinational: (state==IDLE) && !dma_halt && (outstanding<MAX_OUT).
- IDLE:
  - Descriptor accepted -> BURST. Load beat_cnt=desc_len. outstanding increments on the accept cycle.
  - Otherwise, dma_halt=1 -> DRAIN.
  - An accept cannot coincide with halt because desc_ready is gated by dma_halt.
- BURST:
  - beat_valid=1; beat_last=(beat_cnt==0).
  - On beat_valid&&beat_ready with beat_cnt!=0: decrement beat_cnt.
  - On the last beat handshake: go to DRAIN if dma_halt=1, else IDLE.
  - dma_halt mid-burst never truncates; the burst always finishes all desc_len+1 beats.
  - beat_ready stalls of any length are legal. Outputs hold while stalled.
- DRAIN:
  - dma_halt=0 -> IDLE.
  - Otherwise, outstanding_next==0 -> QUIET. outstanding_next includes a cpl arriving this cycle.
- QUIET:
  - tx_quiet=1, derived from the state register, so it rises 1 cycle after the drain condition.
  - dma_halt=0 -> IDLE; tx_quiet falls the next cycle.
- Outstanding counter:
  - outstanding_next = outstanding + accept - (cpl_valid && outstanding!=0).
  - Simultaneous accept and cpl leaves the count unchanged.
  - Saturation is not possible; desc_ready blocks accepts at MAX_OUT.
- cpl_err:
  - cpl_valid with outstanding==0 and no same-cycle accept sets cpl_err.
  - The stray cpl is ignored and the counter stays at 0.
  - Cleared only by rst_n.
- Minimum halt-to-quiet latency:
  - From IDLE with outstanding=0: halt seen in cycle N gives DRAIN at N+1, QUIET at N+2, and tx_quiet=1 from N+2.
- Reset mid-burst: all state is dropped immediately. beat_valid deasserts asynchronously and no completion is awaited.

Decomposition:
- Package dma_tx_pkg holds:
  - the state enum typedef (IDLE, BURST, DRAIN, QUIET);
  - the LEN_W and MAX_OUT default constants;
  - a descriptor struct {len}, shared with the descriptor fetcher.
- One natural sub-module: dma_out_cnt. It is the up/down outstanding counter with full flag, zero-next flag and underflow detect.
- The FSM and beat counter stay in the top module.

Test Plan:
- Basic burst: desc_len=3, beat_ready=1. Expect 4 beats, beat_last only on the 4th. outstanding goes 0->1; a cpl 5 cycles later returns it to 0.
- Backpressure at depth: MAX_OUT=8, issue 8 one-beat bursts with no cpl. Expect desc_ready=0 while outstanding=8. One cpl gives desc_ready=1 the next cycle.
- Halt mid-burst: desc_len=7, assert dma_halt after beat 2 with outstanding=3. Expect all 8 beats issued and tx_quiet=0. After the 3rd cpl (cycle N), tx_quiet=1 at N+1.
- Same-cycle events:
  - An accept coinciding with a cpl at outstanding=2 leaves outstanding=2.
  - A cpl at outstanding=0 sets cpl_err=1, which stays 1 until rst_n.
- Unhalt: in QUIET, drop dma_halt. Expect tx_quiet=0 the next cycle and desc_ready=1 in IDLE.
- Reset mid-operation: pulse rst_n low during beat 3 of an 8-beat burst. Expect beat_valid=0 immediately, then all outputs at reset values and IDLE after release.
